// File: rtl/trigger_frame_writer.sv
// -----------------------------------------------------------------------------
// trigger_frame_writer
//
// Self-triggering front end between the ADC AXI-Stream output and the two
// FIFOs read by the dataframe generator. Every accepted ADC word is compared
// sample-by-sample against a signed threshold. Contiguous runs of triggered
// words are written to the ADC data FIFO. One combined header/footer entry is
// then written to the HF FIFO for each frame. The frame's last ADC write
// always comes no later than its HF write.
//
// The trigger decision is made on the word present at the input. The output
// registers act as the stage-0 capture of word, strobe, timestamp and running
// maximum. As a result, a word at the input in cycle t appears on the FIFO
// write port in cycle t+1.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   CH_ID               channel id placed in the header (quasi-static)
//   THRESHOLD           signed trigger threshold (quasi-static)
//   S_AXIS_*            ADC word stream; TREADY is 0 in reset, 1 otherwise
//   ADC_FIFO_*          ADC data FIFO write port and its full/prog-full flags
//   HF_FIFO_*           header/footer FIFO write port and its full flag
//   DROP_CNT            saturating count of trigger runs dropped for space
//   FRAME_WRITER_ERROR  sticky overflow error (cleared only by ARESET)
// -----------------------------------------------------------------------------
module trigger_frame_writer #(
    parameter int         TDATA_WIDTH        = 128,
    parameter int         SAMPLE_WIDTH       = 16,
    parameter int         FRAME_LENGTH_WIDTH = 12,
    parameter int         MAX_FRAME_LEN      = 256,
    parameter logic [7:0] HEADER_ID          = 8'hAA,
    parameter logic [7:0] FOOTER_ID          = 8'h55
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [7:0]                     CH_ID,
    input  logic signed [SAMPLE_WIDTH-1:0] THRESHOLD,
    input  logic                           S_AXIS_TVALID,
    input  logic [TDATA_WIDTH-1:0]         S_AXIS_TDATA,
    output logic                           S_AXIS_TREADY,
    input  logic                           ADC_FIFO_FULL,
    input  logic                           ADC_FIFO_PROG_FULL,
    output logic                           ADC_FIFO_WR_EN,
    output logic [TDATA_WIDTH-1:0]         ADC_FIFO_DIN,
    input  logic                           HF_FIFO_FULL,
    output logic                           HF_FIFO_WR_EN,
    output logic [191:0]                   HF_FIFO_DIN,
    output logic [15:0]                    DROP_CNT,
    output logic                           FRAME_WRITER_ERROR
);

    localparam int NUM_SAMPLES = TDATA_WIDTH / SAMPLE_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACQ   = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    localparam logic [FRAME_LENGTH_WIDTH-1:0] LEN_ONE = FRAME_LENGTH_WIDTH'(1);
    localparam logic [FRAME_LENGTH_WIDTH-1:0] LEN_MAX = FRAME_LENGTH_WIDTH'(MAX_FRAME_LEN);

    // Returns 1 when any sample of the word is signed-greater than the threshold.
    function automatic logic word_trig(input logic [TDATA_WIDTH-1:0] d,
                                       input logic signed [SAMPLE_WIDTH-1:0] thr);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            hit = hit | ($signed(d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > thr);
        end
        return hit;
    endfunction

    // Returns the largest signed sample contained in the word.
    function automatic logic signed [SAMPLE_WIDTH-1:0] word_max(input logic [TDATA_WIDTH-1:0] d);
        logic signed [SAMPLE_WIDTH-1:0] m;
        logic signed [SAMPLE_WIDTH-1:0] s;
        m = $signed(d[SAMPLE_WIDTH-1:0]);
        for (int k = 1; k < NUM_SAMPLES; k++) begin
            s = $signed(d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
            m = (s > m) ? s : m;
        end
        return m;
    endfunction

    logic [1:0]                     r_state;
    logic [FRAME_LENGTH_WIDTH-1:0]  r_len;
    logic signed [SAMPLE_WIDTH-1:0] r_frame_max;
    logic [47:0]                    r_ts;
    logic [47:0]                    r_ts_start;
    logic [15:0]                    r_seq;
    logic                           r_drop_pending;
    logic [15:0]                    r_drop_cnt;
    logic                           r_err;
    logic                           r_tready;
    logic                           r_adc_we;
    logic [TDATA_WIDTH-1:0]         r_adc_din;
    logic                           r_hf_we;
    logic [191:0]                   r_hf_din;

    logic                           w_trig;
    logic signed [SAMPLE_WIDTH-1:0] w_wmax;
    logic [1:0]                     w_state_nx;
    logic [FRAME_LENGTH_WIDTH-1:0]  w_len_nx;
    logic signed [SAMPLE_WIDTH-1:0] w_max_nx;
    logic [47:0]                    w_ts_start_nx;
    logic                           w_adc_we;
    logic                           w_hf_we;
    logic                           w_trunc;
    logic                           w_drop;
    logic                           w_start;
    logic [191:0]                   w_hf_din;

    // Trigger qualification; a word only counts once it is actually accepted.
    always_comb begin
        w_trig = S_AXIS_TVALID & r_tready & word_trig(S_AXIS_TDATA, THRESHOLD);
        w_wmax = word_max(S_AXIS_TDATA);
    end

    // Frame FSM: decides writes for the word currently on the input.
    always_comb begin
        w_state_nx    = r_state;
        w_len_nx      = r_len;
        w_max_nx      = r_frame_max;
        w_ts_start_nx = r_ts_start;
        w_adc_we      = 1'b0;
        w_hf_we       = 1'b0;
        w_trunc       = 1'b0;
        w_drop        = 1'b0;
        w_start       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start = w_trig;
            end
            ST_ACQ: begin
                if (w_trig && (r_len != LEN_MAX)) begin
                    if (ADC_FIFO_FULL) begin
                        w_state_nx = ST_ERROR;
                    end else begin
                        w_adc_we = 1'b1;
                        w_len_nx = r_len + LEN_ONE;
                        w_max_nx = (w_wmax > r_frame_max) ? w_wmax : r_frame_max;
                    end
                end else begin
                    // Close on a quiet word or on the word after a full frame;
                    // a triggered word after a full frame opens the next one.
                    if (HF_FIFO_FULL) begin
                        w_state_nx = ST_ERROR;
                    end else begin
                        w_hf_we    = 1'b1;
                        w_trunc    = (r_len == LEN_MAX);
                        w_state_nx = ST_IDLE;
                        w_start    = w_trig;
                    end
                end
            end
            ST_DROP: begin
                if (w_trig) begin
                    w_state_nx = ST_DROP;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_ERROR: begin
                w_state_nx = ST_ERROR;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        // Frame start, shared by IDLE and the back-to-back case after truncation.
        if (w_start) begin
            if (ADC_FIFO_PROG_FULL || HF_FIFO_FULL) begin
                w_state_nx = ST_DROP;
                w_drop     = 1'b1;
            end else if (ADC_FIFO_FULL) begin
                w_state_nx = ST_ERROR;
            end else begin
                w_state_nx    = ST_ACQ;
                w_adc_we      = 1'b1;
                w_len_nx      = LEN_ONE;
                w_max_nx      = w_wmax;
                w_ts_start_nx = r_ts;
            end
        end else begin
            w_drop = 1'b0;
        end
    end

    // Header/footer entry for the frame being closed this cycle.
    always_comb begin
        w_hf_din = {HEADER_ID, CH_ID, r_len, 36'd0,
                    r_ts_start, 16'd0,
                    FOOTER_ID, r_seq,
                    6'd0, r_drop_pending, w_trunc,
                    r_frame_max, 16'd0};
    end

    // State, counters and registered FIFO write ports.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state        <= ST_IDLE;
            r_len          <= '0;
            r_frame_max    <= '0;
            r_ts           <= 48'd0;
            r_ts_start     <= 48'd0;
            r_seq          <= 16'd0;
            r_drop_pending <= 1'b0;
            r_drop_cnt     <= 16'd0;
            r_err          <= 1'b0;
            r_tready       <= 1'b0;
            r_adc_we       <= 1'b0;
            r_adc_din      <= '0;
            r_hf_we        <= 1'b0;
            r_hf_din       <= 192'd0;
        end else begin
            r_state     <= w_state_nx;
            r_len       <= w_len_nx;
            r_frame_max <= w_max_nx;
            r_ts        <= r_ts + 48'd1;
            r_ts_start  <= w_ts_start_nx;
            r_tready    <= 1'b1;
            r_err       <= r_err | (w_state_nx == ST_ERROR);
            r_adc_we    <= w_adc_we;
            r_hf_we     <= w_hf_we;
            if (w_adc_we) begin
                r_adc_din <= S_AXIS_TDATA;
            end else begin
                r_adc_din <= r_adc_din;
            end
            if (w_hf_we) begin
                r_hf_din <= w_hf_din;
                r_seq    <= r_seq + 16'd1;
            end else begin
                r_hf_din <= r_hf_din;
                r_seq    <= r_seq;
            end
            // A drop in the same cycle as an HF write re-arms the flag for the next frame.
            if (w_drop) begin
                r_drop_pending <= 1'b1;
            end else if (w_hf_we) begin
                r_drop_pending <= 1'b0;
            end else begin
                r_drop_pending <= r_drop_pending;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    assign S_AXIS_TREADY      = r_tready;
    assign ADC_FIFO_WR_EN     = r_adc_we;
    assign ADC_FIFO_DIN       = r_adc_din;
    assign HF_FIFO_WR_EN      = r_hf_we;
    assign HF_FIFO_DIN        = r_hf_din;
    assign DROP_CNT           = r_drop_cnt;
    assign FRAME_WRITER_ERROR = r_err;

endmodule
